bcd_stopwatch: RTL

BCD_STOPWATCH -- requirements
Module: bcd_stopwatch

---
 rtl/bcd_stopwatch_if.sv | 35 +++
 rtl/bcd_stopwatch.sv | 159 +++++++++++++++
 2 files changed

// File: rtl/bcd_stopwatch_if.sv
// Stopwatch command/status bundle.
// The controller drives the master side; the counter sits on the slave side.
interface bcd_stopwatch_if #(
   parameter int DIGITS  = 4,
   parameter int PRESC_W = 32
);
   localparam int SEL_W = $clog2(PRESC_W);

   logic                  cmd_down;
   logic                  cmd_up;
   logic                  cmd_stop;
   logic                  cmd_clear;
   logic                  load_en;
   logic [4*DIGITS-1:0]   load_val;
   logic                  lap;
   logic                  wrap_en;
   logic [SEL_W-1:0]      presc_sel;
   logic [4*DIGITS-1:0]   digits;
   logic [4*DIGITS-1:0]   lap_digits;
   logic [2:0]            state;
   logic                  tick;
   logic                  bound_hit;

   modport master (
      output cmd_down, cmd_up, cmd_stop, cmd_clear,
      output load_en, load_val, lap, wrap_en, presc_sel,
      input  digits, lap_digits, state, tick, bound_hit
   );

   modport slave (
      input  cmd_down, cmd_up, cmd_stop, cmd_clear,
      input  load_en, load_val, lap, wrap_en, presc_sel,
      output digits, lap_digits, state, tick, bound_hit
   );
endinterface

// File: rtl/bcd_stopwatch.sv
// Up/down BCD stopwatch with prescaled tick, preset load,
// lap capture and stop-or-wrap behaviour at the count bounds.
module bcd_stopwatch #(
   parameter int DIGITS  = 4,
   parameter int PRESC_W = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   bcd_stopwatch_if.slave   sw
);
   localparam int DW = 4 * DIGITS;
   localparam logic [PRESC_W-1:0] P_ONE = 1;

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      STOP  = 3'd1,
      BOUND = 3'd2,
      UP    = 3'd3,
      DOWN  = 3'd4
   } state_t;

   state_t             state_q, state_n;
   logic [DW-1:0]      digits_q, digits_n;
   logic [DW-1:0]      lap_q, lap_n;
   logic [PRESC_W-1:0] presc_q, presc_n;
   logic               tick_q, tick_n;
   logic               bound_q, bound_n;

   logic [DW-1:0]      inc_v, dec_v, ld_v;
   logic [PRESC_W-1:0] limit;
   logic               cy, bw, all9, all0;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= IDLE;
         digits_q <= '0;
         lap_q    <= '0;
         presc_q  <= '0;
         tick_q   <= 1'b0;
         bound_q  <= 1'b0;
      end else begin
         state_q  <= state_n;
         digits_q <= digits_n;
         lap_q    <= lap_n;
         presc_q  <= presc_n;
         tick_q   <= tick_n;
         bound_q  <= bound_n;
      end
   end

   // Ripple increment/decrement; the carry/borrow out flags the bound.
   always_comb begin
      inc_v = '0;
      dec_v = '0;
      ld_v  = '0;
      cy    = 1'b1;
      bw    = 1'b1;
      for (int i = 0; i < DIGITS; i++) begin
         if (cy) begin
            if (digits_q[4*i +: 4] == 4'd9) begin
               inc_v[4*i +: 4] = 4'd0;
            end else begin
               inc_v[4*i +: 4] = digits_q[4*i +: 4] + 4'd1;
               cy = 1'b0;
            end
         end else begin
            inc_v[4*i +: 4] = digits_q[4*i +: 4];
         end
         if (bw) begin
            if (digits_q[4*i +: 4] == 4'd0) begin
               dec_v[4*i +: 4] = 4'd9;
            end else begin
               dec_v[4*i +: 4] = digits_q[4*i +: 4] - 4'd1;
               bw = 1'b0;
            end
         end else begin
            dec_v[4*i +: 4] = digits_q[4*i +: 4];
         end
         if (sw.load_val[4*i +: 4] > 4'd9) begin
            ld_v[4*i +: 4] = 4'd9;
         end else begin
            ld_v[4*i +: 4] = sw.load_val[4*i +: 4];
         end
      end
      all9 = cy;
      all0 = bw;
   end

   // 2^sel - 1; using >= lets a shrinking period expire at once.
   assign limit = (P_ONE << sw.presc_sel) - P_ONE;

   always_comb begin
      state_n  = state_q;
      digits_n = digits_q;
      presc_n  = presc_q;
      tick_n   = 1'b0;
      bound_n  = 1'b0;
      lap_n    = sw.lap ? digits_q : lap_q;
      priority case (1'b1)
         sw.cmd_clear: begin
            digits_n = '0;
            presc_n  = '0;
            state_n  = IDLE;
         end
         sw.load_en: begin
            digits_n = ld_v;
            presc_n  = '0;
            state_n  = STOP;
         end
         sw.cmd_down: begin
            presc_n = '0;
            state_n = DOWN;
         end
         sw.cmd_up: begin
            presc_n = '0;
            state_n = UP;
         end
         sw.cmd_stop: begin
            presc_n = '0;
            state_n = STOP;
         end
         default: begin
            if (state_q == UP || state_q == DOWN) begin
               if (presc_q >= limit) begin
                  presc_n = '0;
                  tick_n  = 1'b1;
                  if (state_q == UP) begin
                     if (all9) begin
                        bound_n = 1'b1;
                        if (sw.wrap_en) digits_n = '0;
                        else state_n = BOUND;
                     end else begin
                        digits_n = inc_v;
                     end
                  end else begin
                     if (all0) begin
                        bound_n = 1'b1;
                        if (sw.wrap_en) digits_n = dec_v;
                        else state_n = BOUND;
                     end else begin
                        digits_n = dec_v;
                     end
                  end
               end else begin
                  presc_n = presc_q + P_ONE;
               end
            end else begin
               presc_n = '0;
            end
         end
      endcase
   end

   assign sw.digits     = digits_q;
   assign sw.lap_digits = lap_q;
   assign sw.state      = state_q;
   assign sw.tick       = tick_q;
   assign sw.bound_hit  = bound_q;
endmodule
